// File: rtl/simple_adapter_split.sv
`default_nettype none
// ============================================================================
// Module   : simple_adapter_split
// Purpose  : Width downsizer. Takes one wide word per handshake and emits it
//            as up to RATIO narrow beats, lowest lane first. A final word of
//            a packet may carry fewer valid lanes; only those are emitted.
// Revision : 1.0 - initial release
// ============================================================================
module simple_adapter_split #(
    parameter  int WIDTH_DOUT  = 16,
    parameter  int RATIO       = 8,
    localparam int WIDTH_DIN   = WIDTH_DOUT * RATIO,
    localparam int WIDTH_LANES = $clog2(RATIO + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_vld,
    output logic                   din_rdy,
    input  logic                   din_last,
    input  logic [WIDTH_LANES-1:0] din_lanes,
    input  logic [WIDTH_DIN-1:0]   din,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic                   dout_last,
    output logic [WIDTH_DOUT-1:0]  dout
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    localparam logic [WIDTH_LANES-1:0] c_ratio = WIDTH_LANES'(RATIO);
    localparam logic [WIDTH_LANES-1:0] c_one   = WIDTH_LANES'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WIDTH_DIN-1:0]    r_hold;
    logic [WIDTH_LANES-1:0]  r_idx;       // lane currently presented on dout
    logic [WIDTH_LANES-1:0]  r_cnt;       // number of lanes in the held word
    logic                    r_pkt_last;  // held word ends a packet
    logic [WIDTH_DOUT-1:0]   r_dout;
    logic                    r_dout_last;

    logic                    w_din_rdy;
    logic                    w_in_acc;
    logic                    w_out_acc;
    logic                    w_final;
    logic [WIDTH_LANES-1:0]  w_cnt_in;
    logic [WIDTH_LANES-1:0]  w_idx_next;
    logic [WIDTH_LANES-1:0]  w_hold_lane;
    logic [WIDTH_DOUT-1:0]   w_lane_next;

    // A lane count of zero or beyond RATIO is meaningless; treat it as a full word.
    assign w_cnt_in   = (din_last && (din_lanes != '0) && (din_lanes <= c_ratio)) ? din_lanes : c_ratio;
    assign w_idx_next = r_idx + c_one;
    assign w_final    = (r_state == BUSY) && (r_idx == (r_cnt - c_one));
    assign w_in_acc   = din_vld && w_din_rdy;
    assign w_out_acc  = dout_vld && dout_rdy;
    assign w_hold_lane = w_idx_next;

    // Next beat: lane 0 of a fresh word, otherwise the following lane of the held word.
    always_comb begin
        w_lane_next = din[WIDTH_DOUT-1:0];
        if (!w_in_acc) begin
            w_lane_next = '0;
            for (int i = 0; i < RATIO; i++) begin
                if (w_hold_lane == WIDTH_LANES'(i)) begin
                    w_lane_next = r_hold[i*WIDTH_DOUT +: WIDTH_DOUT];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and input-ready: a new word is only taken once the last lane leaves.
    always_comb begin
        w_state_next = r_state;
        w_din_rdy    = 1'b0;
        case (r_state)
            EMPTY: begin
                w_din_rdy = 1'b1;
                if (din_vld) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_din_rdy = w_final && dout_rdy;
                if (w_final && dout_rdy && !din_vld) begin
                    w_state_next = EMPTY;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
        if (rst) begin
            w_din_rdy = 1'b0;
        end
    end

    // Datapath: capture words, step through lanes, register the output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_pkt_last  <= 1'b0;
            r_dout      <= '0;
            r_dout_last <= 1'b0;
        end else if (w_in_acc) begin
            r_hold      <= din;
            r_cnt       <= w_cnt_in;
            r_idx       <= '0;
            r_pkt_last  <= din_last;
            r_dout      <= w_lane_next;
            r_dout_last <= din_last && (w_cnt_in == c_one);
        end else if (w_out_acc && !w_final) begin
            r_idx       <= w_idx_next;
            r_dout      <= w_lane_next;
            r_dout_last <= r_pkt_last && (w_idx_next == (r_cnt - c_one));
        end else if (w_out_acc) begin
            r_dout_last <= 1'b0;
        end
    end

    assign din_rdy   = w_din_rdy;
    assign dout_vld  = (r_state == BUSY);
    assign dout_last = r_dout_last;
    assign dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_simple_adapter_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_adapter_split
// Purpose  : Self-checking bench for simple_adapter_split (RATIO=8, 16-bit
//            beats): directed vector table plus streaming/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_adapter_split;

    logic         clk;
    logic         rst;
    logic         din_vld;
    logic         din_rdy;
    logic         din_last;
    logic [3:0]   din_lanes;
    logic [127:0] din;
    logic         dout_vld;
    logic         dout_rdy;
    logic         dout_last;
    logic [15:0]  dout;

    int checks = 0;
    int errors = 0;

    simple_adapter_split #(.WIDTH_DOUT(16), .RATIO(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .din_last  (din_last),
        .din_lanes (din_lanes),
        .din       (din),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_last (dout_last),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic         last;
        logic [3:0]   lanes;
        int           exp_n;
        logic         exp_last;
    } vec_t;

    vec_t vecs[7];

    // Word list for streaming runs
    logic [127:0] s_din[$];
    logic         s_last[$];
    logic [3:0]   s_lanes[$];
    int           s_beats;
    int           s_lasts;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Send one word with dout_rdy=1 and check every beat and the idle afterwards.
    task automatic run_vec(input vec_t v, input string nm);
        logic         acc;
        logic [127:0] w;
        din       = v.din;
        din_last  = v.last;
        din_lanes = v.lanes;
        din_vld   = 1'b1;
        dout_rdy  = 1'b1;
        acc       = 1'b0;
        for (int t = 0; t < 16 && !acc; t++) begin
            #1;
            acc = din_rdy;
            @(posedge clk); #1;
        end
        din_vld = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL %s accept: got no handshake expected one", nm);
            return;
        end
        w = v.din;
        for (int b = 0; b < v.exp_n; b++) begin
            chk({nm, " vld"}, dout_vld, 1'b1);
            chk({nm, " data"}, dout, w[b*16 +: 16]);
            chk({nm, " last"}, dout_last, v.exp_last && (b == v.exp_n - 1));
            @(posedge clk); #1;
        end
        chk({nm, " idle vld"}, dout_vld, 1'b0);
        chk({nm, " idle last"}, dout_last, 1'b0);
    endtask

    // Stream the word list through with random handshakes against a beat scoreboard.
    task automatic stream(input int rdy_pct, input int vld_pct, input string nm);
        logic [16:0]  q[$];
        int           wi;
        int           cyc;
        int           n;
        logic         prev_in;
        logic         prev_out;
        logic         prev_hold;
        logic [15:0]  prev_dout;
        logic         prev_lastv;
        logic [127:0] w;
        logic [16:0]  e;
        wi = 0; cyc = 0;
        prev_in = 1'b0; prev_out = 1'b0; prev_hold = 1'b0;
        prev_dout = '0; prev_lastv = 1'b0;
        s_beats = 0; s_lasts = 0;
        din_vld = 1'b0;
        while (cyc < 20000) begin
            if (prev_out) void'(q.pop_front());
            if (prev_in) begin
                n = (s_last[wi] && s_lanes[wi] != 0 && s_lanes[wi] <= 8) ? int'(s_lanes[wi]) : 8;
                w = s_din[wi];
                for (int b = 0; b < n; b++) q.push_back({s_last[wi] && (b == n - 1), w[b*16 +: 16]});
                wi++;
            end
            chk({nm, " vld"}, dout_vld, q.size() != 0);
            if (dout_vld && q.size() != 0) begin
                e = q[0];
                chk({nm, " data"}, dout, e[15:0]);
                chk({nm, " last"}, dout_last, e[16]);
            end
            if (prev_hold) begin
                chk({nm, " stable data"}, dout, prev_dout);
                chk({nm, " stable last"}, dout_last, prev_lastv);
            end
            if (wi == s_din.size() && q.size() == 0) break;
            if (!din_vld || prev_in) begin
                if (wi < s_din.size() && $urandom_range(0, 99) < vld_pct) begin
                    din_vld   = 1'b1;
                    din       = s_din[wi];
                    din_last  = s_last[wi];
                    din_lanes = s_lanes[wi];
                end else begin
                    din_vld = 1'b0;
                end
            end
            dout_rdy = ($urandom_range(0, 99) < rdy_pct);
            #1;
            chk({nm, " din_rdy"}, din_rdy, (q.size() == 0) || (q.size() == 1 && dout_rdy));
            prev_in    = din_vld && din_rdy;
            prev_out   = dout_vld && dout_rdy;
            prev_hold  = dout_vld && !dout_rdy;
            prev_dout  = dout;
            prev_lastv = dout_last;
            if (prev_out) begin
                s_beats++;
                if (dout_last) s_lasts++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d cycles expected completion", nm, cyc);
        end
        din_vld = 1'b0;
        s_din.delete(); s_last.delete(); s_lanes.delete();
    endtask

    initial begin
        logic [127:0] tmp;
        logic         acc;
        logic         lst;

        vecs[0] = '{128'h0007_0006_0005_0004_0003_0002_0001_0000, 1'b1, 4'd8,  8, 1'b1};
        vecs[1] = '{128'hDEAD_BEEF_1234_5678_9ABC_CCCC_BBBB_AAAA, 1'b1, 4'd3,  3, 1'b1};
        vecs[2] = '{128'h1117_1116_1115_1114_1113_1112_1111_1110, 1'b1, 4'd0,  8, 1'b1};
        vecs[3] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_5A5A, 1'b1, 4'd1,  1, 1'b1};
        vecs[4] = '{128'h2227_2226_2225_2224_2223_2222_2221_2220, 1'b0, 4'd2,  8, 1'b0};
        vecs[5] = '{128'h3337_3336_3335_3334_3333_3332_3331_3330, 1'b1, 4'hF,  8, 1'b1};
        vecs[6] = '{128'h0000_4446_4445_4444_4443_4442_4441_4440, 1'b1, 4'd7,  7, 1'b1};

        rst = 1'b1; din_vld = 1'b0; din_last = 1'b0; din_lanes = '0; din = '0; dout_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset din_rdy", din_rdy, 1'b0);
        chk("reset vld", dout_vld, 1'b0);
        chk("reset last", dout_last, 1'b0);
        chk("reset dout", dout, 16'h0);
        rst = 1'b0;
        #1;
        chk("post-reset din_rdy", din_rdy, 1'b1);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back streaming of 4 full words
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) tmp[i*16 +: 16] = 16'(w * 256 + i);
            s_din.push_back(tmp); s_last.push_back(w == 3); s_lanes.push_back(4'd8);
        end
        stream(100, 100, "b2b");
        chk("b2b beats", s_beats, 32);
        chk("b2b lasts", s_lasts, 1);

        // Partial word followed directly by further words
        s_din.push_back(vecs[1].din); s_last.push_back(1'b1); s_lanes.push_back(4'd3);
        s_din.push_back(vecs[4].din); s_last.push_back(1'b0); s_lanes.push_back(4'd2);
        s_din.push_back(vecs[0].din); s_last.push_back(1'b1); s_lanes.push_back(4'd8);
        stream(100, 100, "partial");
        chk("partial beats", s_beats, 19);
        chk("partial lasts", s_lasts, 2);

        // Random backpressure: 128 full words, 1024 beats
        for (int w = 0; w < 128; w++) begin
            for (int i = 0; i < 8; i++) tmp[i*16 +: 16] = 16'($urandom);
            lst = (w == 127) || ($urandom_range(0, 7) == 0);
            s_din.push_back(tmp); s_last.push_back(lst);
            s_lanes.push_back(lst ? ($urandom_range(0, 1) ? 4'd8 : 4'd0) : 4'($urandom_range(0, 15)));
        end
        stream(20, 50, "random");
        chk("random beats", s_beats, 1024);

        // Reset in the middle of a word
        din = vecs[0].din; din_last = 1'b1; din_lanes = 4'd8; din_vld = 1'b1; dout_rdy = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 16 && !acc; t++) begin
            #1;
            acc = din_rdy;
            @(posedge clk); #1;
        end
        din_vld = 1'b0;
        chk("midreset accept", acc, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("midreset lane3", dout, 16'h0003);
        rst = 1'b1;
        #1;
        chk("midreset din_rdy low", din_rdy, 1'b0);
        @(posedge clk); #1;
        chk("midreset vld", dout_vld, 1'b0);
        chk("midreset last", dout_last, 1'b0);
        chk("midreset dout", dout, 16'h0);
        rst = 1'b0;
        #1;
        chk("midreset din_rdy", din_rdy, 1'b1);
        run_vec(vecs[6], "after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
